// File: rtl/parking_gate_ctrl.sv
// Gate sequencer: synchronizes the two beam sensors, tracks entry/exit sequences and
// pulses the occupancy counter, with full/empty flags and reject/illegal-sequence pulses.
module parking_gate_ctrl #(
   parameter int WIDTH    = 4,
   parameter int CAPACITY = 25
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           a,
   input  logic           b,
   input  logic [WIDTH:0] occ,
   output logic           inc,
   output logic           dec,
   output logic           full,
   output logic           empty,
   output logic           reject,
   output logic           err
);

   localparam logic [WIDTH:0] CAP_OCC = (WIDTH+1)'(CAPACITY);

   typedef enum logic [2:0] {
      IDLE, EN1, EN2, EN3, EX1, EX2, EX3, ERR
   } state_t;

   state_t     state, next_state;
   logic       a_meta, a_sync, b_meta, b_sync;
   logic [1:0] sens;
   logic       entry_evt, exit_evt;
   logic       inc_next, dec_next, reject_next, err_next;

   // Raw sensors are asynchronous to clk, so each gets two flops before the FSM sees it
   always_ff @(posedge clk) begin
      if (reset) begin
         a_meta <= 1'b0;
         a_sync <= 1'b0;
         b_meta <= 1'b0;
         b_sync <= 1'b0;
      end else begin
         a_meta <= a;
         a_sync <= a_meta;
         b_meta <= b;
         b_sync <= b_meta;
      end
   end

   assign sens = {a_sync, b_sync};

   always_ff @(posedge clk) begin
      if (reset) begin
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         full  <= (occ >= CAP_OCC);
         empty <= (occ == '0);
      end
   end

   always_comb begin
      next_state  = state;
      entry_evt   = 1'b0;
      exit_evt    = 1'b0;
      inc_next    = 1'b0;
      dec_next    = 1'b0;
      reject_next = 1'b0;
      err_next    = 1'b0;

      case (state)
         IDLE: case (sens)
            2'b10:   next_state = EN1;
            2'b01:   next_state = EX1;
            2'b00:   next_state = IDLE;
            default: next_state = ERR;
         endcase
         EN1: case (sens)
            2'b11:   next_state = EN2;
            2'b00:   next_state = IDLE;
            2'b10:   next_state = EN1;
            default: next_state = ERR;
         endcase
         EN2: case (sens)
            2'b01:   next_state = EN3;
            2'b10:   next_state = EN1;
            2'b11:   next_state = EN2;
            default: next_state = ERR;
         endcase
         EN3: case (sens)
            2'b00: begin
               next_state = IDLE;
               entry_evt  = 1'b1;
            end
            2'b11:   next_state = EN2;
            2'b01:   next_state = EN3;
            default: next_state = ERR;
         endcase
         EX1: case (sens)
            2'b11:   next_state = EX2;
            2'b00:   next_state = IDLE;
            2'b01:   next_state = EX1;
            default: next_state = ERR;
         endcase
         EX2: case (sens)
            2'b10:   next_state = EX3;
            2'b01:   next_state = EX1;
            2'b11:   next_state = EX2;
            default: next_state = ERR;
         endcase
         EX3: case (sens)
            2'b00: begin
               next_state = IDLE;
               exit_evt   = 1'b1;
            end
            2'b11:   next_state = EX2;
            2'b10:   next_state = EX3;
            default: next_state = ERR;
         endcase
         ERR: begin
            if (sens == 2'b00) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase

      // err fires only on the edge into ERR, plus an exit seen while the lot is already empty
      if (next_state == ERR && state != ERR) begin
         err_next = 1'b1;
      end
      if (entry_evt) begin
         if (full) begin
            reject_next = 1'b1;
         end else begin
            inc_next = 1'b1;
         end
      end
      if (exit_evt) begin
         if (empty) begin
            err_next = 1'b1;
         end else begin
            dec_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         inc    <= 1'b0;
         dec    <= 1'b0;
         reject <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= next_state;
         inc    <= inc_next;
         dec    <= dec_next;
         reject <= reject_next;
         err    <= err_next;
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl: directed sensor sequences push the expected
// pulse and its arrival cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_parking_gate_ctrl;

   localparam logic [3:0] P_NONE = 4'b0000;
   localparam logic [3:0] P_INC  = 4'b1000;
   localparam logic [3:0] P_DEC  = 4'b0100;
   localparam logic [3:0] P_REJ  = 4'b0010;
   localparam logic [3:0] P_ERR  = 4'b0001;

   typedef struct {
      logic [3:0] pulses;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic [4:0] occ;
   logic       inc, dec, full, empty, reject, err;

   exp_t sbQ[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   parking_gate_ctrl #(.WIDTH(4), .CAPACITY(25)) dut (
      .clk    (clk),
      .reset  (reset),
      .a      (a),
      .b      (b),
      .occ    (occ),
      .inc    (inc),
      .dec    (dec),
      .full   (full),
      .empty  (empty),
      .reject (reject),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Pulses appear three edges after the raw change, so that is the cycle the monitor expects
   task automatic applyStimulus(input logic [1:0] ab, input logic [3:0] expPulse);
      @(negedge clk);
      {a, b} = ab;
      if (expPulse != P_NONE) begin
         sbQ.push_back('{pulses: expPulse, cyc: cyc + 3});
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic setOcc(input logic [4:0] value, input logic expFull, input logic expEmpty);
      @(negedge clk);
      occ = value;
      repeat (2) @(negedge clk);
      checkOutput($sformatf("full_occ%0d", value), 32'(full), 32'(expFull));
      checkOutput($sformatf("empty_occ%0d", value), 32'(empty), 32'(expEmpty));
   endtask

   task automatic entrySeq(input logic [3:0] expPulse);
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b11, P_NONE);
      applyStimulus(2'b01, P_NONE);
      applyStimulus(2'b00, expPulse);
   endtask

   task automatic exitSeq(input logic [3:0] expPulse);
      applyStimulus(2'b01, P_NONE);
      applyStimulus(2'b11, P_NONE);
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b00, expPulse);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         logic [3:0] got;
         got = {inc, dec, reject, err};
         if (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
            checkOutput("missing_pulse", 32'(P_NONE), 32'(sbQ[0].pulses));
            void'(sbQ.pop_front());
         end
         if (got != P_NONE) begin
            if (sbQ.size() == 0) begin
               checkOutput("unexpected_pulse", 32'(got), 32'(P_NONE));
            end else begin
               exp_t e;
               e = sbQ.pop_front();
               checkOutput("pulse_value", 32'(got), 32'(e.pulses));
               checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      a     = 1'b0;
      b     = 1'b0;
      occ   = 5'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset_pulses", 32'({inc, dec, reject, err}), 32'(P_NONE));
      checkOutput("reset_full", 32'(full), 32'(0));
      checkOutput("reset_empty", 32'(empty), 32'(1));
      occ = 5'd5;
      @(negedge clk);
      checkOutput("reset_holds_empty", 32'(empty), 32'(1));
      occ = 5'd0;
      reset = 1'b0;

      // Basic entry and exit
      setOcc(5'd0, 1'b0, 1'b1);
      applyStimulus(2'b00, P_NONE);
      entrySeq(P_INC);
      setOcc(5'd5, 1'b0, 1'b0);
      exitSeq(P_DEC);

      // Back out halfway, then a clean entry proves the FSM is back in IDLE
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b11, P_NONE);
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b00, P_NONE);
      entrySeq(P_INC);

      // Capacity boundaries: 24 not full, 25 and above full
      setOcc(5'd24, 1'b0, 1'b0);
      setOcc(5'd25, 1'b1, 1'b0);
      entrySeq(P_REJ);
      setOcc(5'd30, 1'b1, 1'b0);
      entrySeq(P_REJ);
      setOcc(5'd0, 1'b0, 1'b1);
      exitSeq(P_ERR);

      // Illegal jump: single err, stays stuck until both beams clear
      applyStimulus(2'b11, P_ERR);
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b01, P_NONE);
      applyStimulus(2'b00, P_NONE);
      entrySeq(P_INC);

      // Reset while in EN2 abandons the car
      setOcc(5'd7, 1'b0, 1'b0);
      applyStimulus(2'b10, P_NONE);
      applyStimulus(2'b11, P_NONE);
      @(negedge clk);
      reset = 1'b1;
      a     = 1'b0;
      b     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("midseq_reset_pulses", 32'({inc, dec, reject, err}), 32'(P_NONE));
      checkOutput("midseq_reset_full", 32'(full), 32'(0));
      checkOutput("midseq_reset_empty", 32'(empty), 32'(1));
      reset = 1'b0;
      applyStimulus(2'b00, P_NONE);
      exitSeq(P_DEC);

      repeat (6) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
